// File: rtl/her_dispatch_sched.sv
// rtl/her_dispatch_sched.sv - HER task dispatcher with per-cluster occupancy tracking and feedback arbiter
//
// Purpose: accepts tasks from the MPQ engine and dispatches each to one of
// NUM_CLUSTERS cluster schedulers according to mode_i (home-first,
// least-loaded or round-robin). It reserves HER slots and L1 packet-buffer
// bytes per cluster at dispatch and releases them on cluster feedback.
// Cluster feedbacks are merged round-robin onto the single pktgen feedback
// interface.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mode_i                        00/11 home-first, 01 least-loaded, 10 round-robin
//   task_valid_i/ready_o          task handshake from MPQ (ready is combinational)
//   task_descr_i, task_bytes_i    task descriptor and its packet bytes
//   cluster_task_valid_o/ready_i  per-cluster registered task outputs
//   cluster_task_descr_o          per-cluster registered task descriptor
//   cluster_feedback_valid_i      per-cluster feedback request
//   cluster_feedback_ready_o      one-hot feedback grant
//   cluster_feedback_i/bytes_i    feedback descriptor and bytes released
//   pktgen_feedback_valid_o/ready_i/pktgen_feedback_o  registered merged feedback
//   occ_err_o                     sticky occupancy underflow flag

package her_dispatch_pkg;
  typedef struct packed {
    logic [15:0] msgid;
    logic [31:0] handler_addr;
  } handler_task_t;

  typedef struct packed {
    logic [15:0] msgid;
    logic [7:0]  status;
  } feedback_descr_t;
endpackage

module her_dispatch_sched
  import her_dispatch_pkg::*;
#(
  parameter int NUM_CLUSTERS = 4,
  parameter int MAX_SLOTS    = 64,
  parameter int MAX_BYTES    = 65536,
  parameter int BYTES_W      = 17
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [1:0]                            mode_i,
  input  logic                                  task_valid_i,
  output logic                                  task_ready_o,
  input  handler_task_t                         task_descr_i,
  input  logic [BYTES_W-1:0]                    task_bytes_i,
  output logic [NUM_CLUSTERS-1:0]               cluster_task_valid_o,
  input  logic [NUM_CLUSTERS-1:0]               cluster_task_ready_i,
  output handler_task_t [NUM_CLUSTERS-1:0]      cluster_task_descr_o,
  input  logic [NUM_CLUSTERS-1:0]               cluster_feedback_valid_i,
  output logic [NUM_CLUSTERS-1:0]               cluster_feedback_ready_o,
  input  feedback_descr_t [NUM_CLUSTERS-1:0]    cluster_feedback_i,
  input  logic [NUM_CLUSTERS-1:0][BYTES_W-1:0]  cluster_feedback_bytes_i,
  output logic                                  pktgen_feedback_valid_o,
  input  logic                                  pktgen_feedback_ready_i,
  output feedback_descr_t                       pktgen_feedback_o,
  output logic                                  occ_err_o
);

  localparam int CW = $clog2(NUM_CLUSTERS);
  localparam int SW = $clog2(MAX_SLOTS) + 1;
  localparam logic [SW-1:0]      SLOT_MAX = SW'(MAX_SLOTS);
  localparam logic [BYTES_W:0]   BYTE_MAX = (BYTES_W + 1)'(MAX_BYTES);
  localparam logic [1:0]         MODE_LL  = 2'b01;
  localparam logic [1:0]         MODE_RR  = 2'b10;

  logic [NUM_CLUSTERS-1:0][SW-1:0]      slot_occ_q, slot_nxt;
  logic [NUM_CLUSTERS-1:0][BYTES_W-1:0] byte_occ_q, byte_nxt;
  logic [NUM_CLUSTERS-1:0]              uflow;
  logic [NUM_CLUSTERS-1:0]              eligible;
  logic [NUM_CLUSTERS-1:0]              ctv_q;
  handler_task_t [NUM_CLUSTERS-1:0]     ctd_q;
  logic                                 pfv_q;
  feedback_descr_t                      pfd_q;
  logic                                 occ_err_q;

  logic [CW-1:0]        task_rr_q, fb_rr_q;
  logic [CW-1:0]        home, sel, ll_idx, rr_idx, rr_cand, fb_idx, fb_cand;
  logic                 ll_found, rr_found, fb_found, fb_can, accept;
  logic [BYTES_W-1:0]   ll_min;
  logic [NUM_CLUSTERS-1:0] fb_grant;
  logic [SW:0]          slot_tmp;
  logic [BYTES_W+1:0]   byte_tmp;
  logic                 inc, dec;

  // A cluster can take a task only if its output register is free (or
  // emptying this cycle) and the reservation fits; the byte sum is one bit
  // wider so it can never wrap below the limit.
  always_comb begin
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      eligible[i] = (slot_occ_q[i] < SLOT_MAX) &&
                    (({1'b0, byte_occ_q[i]} + {1'b0, task_bytes_i}) <= BYTE_MAX) &&
                    (!ctv_q[i] || cluster_task_ready_i[i]);
    end
  end

  // Least-loaded: strict '<' keeps the lowest index on ties.
  always_comb begin
    ll_found = 1'b0;
    ll_idx   = '0;
    ll_min   = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      if (eligible[i] && (!ll_found || byte_occ_q[i] < ll_min)) begin
        ll_found = 1'b1;
        ll_idx   = CW'(i);
        ll_min   = byte_occ_q[i];
      end
    end
  end

  // Round-robin: scan starting one past the pointer; the last candidate
  // (offset NUM_CLUSTERS wraps to 0) is the pointer itself.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_CLUSTERS; k++) begin
      rr_cand = task_rr_q + CW'(k);
      if (!rr_found && eligible[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign home = task_descr_i.msgid[CW-1:0];

  always_comb begin
    case (mode_i)
      MODE_LL: sel = ll_idx;
      MODE_RR: sel = rr_idx;
      default: sel = eligible[home] ? home : ll_idx;
    endcase
  end

  assign accept       = task_valid_i && (|eligible);
  assign task_ready_o = accept;

  // Feedback arbiter: same rotating scan as the task round-robin.
  assign fb_can = !pfv_q || pktgen_feedback_ready_i;

  always_comb begin
    fb_found = 1'b0;
    fb_idx   = '0;
    fb_cand  = '0;
    for (int k = 1; k <= NUM_CLUSTERS; k++) begin
      fb_cand = fb_rr_q + CW'(k);
      if (!fb_found && cluster_feedback_valid_i[fb_cand]) begin
        fb_found = 1'b1;
        fb_idx   = fb_cand;
      end
    end
    fb_grant = '0;
    if (fb_can && fb_found) fb_grant[fb_idx] = 1'b1;
  end

  assign cluster_feedback_ready_o = fb_grant;

  // Occupancy next state: reservation and release combine into one net
  // change; a negative result saturates at zero and flags underflow.
  always_comb begin
    slot_tmp = '0;
    byte_tmp = '0;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      inc      = accept && (sel == CW'(i));
      dec      = fb_grant[i];
      slot_tmp = {1'b0, slot_occ_q[i]} + {{SW{1'b0}}, inc} - {{SW{1'b0}}, dec};
      byte_tmp = {2'b00, byte_occ_q[i]}
               + (inc ? {2'b00, task_bytes_i} : '0)
               - (dec ? {2'b00, cluster_feedback_bytes_i[i]} : '0);
      uflow[i] = slot_tmp[SW] || byte_tmp[BYTES_W+1];
      slot_nxt[i] = slot_tmp[SW] ? '0 : slot_tmp[SW-1:0];
      if (byte_tmp[BYTES_W+1]) byte_nxt[i] = '0;
      else if (byte_tmp[BYTES_W]) byte_nxt[i] = '1;
      else byte_nxt[i] = byte_tmp[BYTES_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_occ_q <= '0;
      byte_occ_q <= '0;
      occ_err_q  <= 1'b0;
      task_rr_q  <= '0;
      fb_rr_q    <= '0;
      ctv_q      <= '0;
      ctd_q      <= '0;
      pfv_q      <= 1'b0;
      pfd_q      <= '0;
    end else begin
      slot_occ_q <= slot_nxt;
      byte_occ_q <= byte_nxt;
      occ_err_q  <= occ_err_q | (|uflow);
      if (accept) task_rr_q <= sel;
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        if (accept && (sel == CW'(i))) begin
          ctv_q[i] <= 1'b1;
          ctd_q[i] <= task_descr_i;
        end else if (cluster_task_ready_i[i]) begin
          ctv_q[i] <= 1'b0;
        end
      end
      if (|fb_grant) begin
        pfv_q   <= 1'b1;
        pfd_q   <= cluster_feedback_i[fb_idx];
        fb_rr_q <= fb_idx;
      end else if (pktgen_feedback_ready_i) begin
        pfv_q <= 1'b0;
      end
    end
  end

  assign cluster_task_valid_o    = ctv_q;
  assign cluster_task_descr_o    = ctd_q;
  assign pktgen_feedback_valid_o = pfv_q;
  assign pktgen_feedback_o       = pfd_q;
  assign occ_err_o               = occ_err_q;

endmodule

// File: tb/tb_her_dispatch_sched.sv
// tb/tb_her_dispatch_sched.sv - scoreboard bench for her_dispatch_sched
module tb_her_dispatch_sched;
  import her_dispatch_pkg::*;

  localparam int N  = 4;
  localparam int MS = 8;
  localparam int MB = 1024;
  localparam int BW = 11;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [1:0]                mode = 2'b00;
  logic                      task_valid = 1'b0;
  logic                      task_ready;
  handler_task_t             task_descr = '0;
  logic [BW-1:0]             task_bytes = '0;
  logic [N-1:0]              ctv;
  logic [N-1:0]              cready = '1;
  handler_task_t [N-1:0]     ctd;
  logic [N-1:0]              fb_valid = '0;
  logic [N-1:0]              fb_ready;
  feedback_descr_t [N-1:0]   fb = '0;
  logic [N-1:0][BW-1:0]      fb_bytes = '0;
  logic                      pfv;
  logic                      pready = 1'b1;
  feedback_descr_t           pfd;
  logic                      occ_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          cl;
    logic [15:0] msgid;
    int          cyc;
  } texp_t;

  texp_t       tq[$];
  logic [15:0] fq[$];

  her_dispatch_sched #(
    .NUM_CLUSTERS(N), .MAX_SLOTS(MS), .MAX_BYTES(MB), .BYTES_W(BW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
    .task_valid_i(task_valid), .task_ready_o(task_ready),
    .task_descr_i(task_descr), .task_bytes_i(task_bytes),
    .cluster_task_valid_o(ctv), .cluster_task_ready_i(cready),
    .cluster_task_descr_o(ctd),
    .cluster_feedback_valid_i(fb_valid), .cluster_feedback_ready_o(fb_ready),
    .cluster_feedback_i(fb), .cluster_feedback_bytes_i(fb_bytes),
    .pktgen_feedback_valid_o(pfv), .pktgen_feedback_ready_i(pready),
    .pktgen_feedback_o(pfd), .occ_err_o(occ_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes an output handshake.
  texp_t       m_e;
  logic [15:0] m_f;
  logic        hold_pending = 1'b0;
  logic [15:0] held_id = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ctv[i] && cready[i]) begin
          if (tq.size() == 0) begin
            checks++; errors++;
            $display("FAIL task_unexpected: got cluster %0d msgid %0h expected none", i, ctd[i].msgid);
          end else begin
            m_e = tq.pop_front();
            check("task_cluster", i, m_e.cl);
            check("task_msgid", ctd[i].msgid, m_e.msgid);
            check("task_latency_cycle", cyc, m_e.cyc);
          end
        end
      end
      if (hold_pending) begin
        check("pktgen_hold_valid", pfv, 1);
        check("pktgen_hold_data", pfd.msgid, held_id);
      end
      hold_pending = pfv && !pready;
      held_id      = pfd.msgid;
      if (pfv && pready) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fb_unexpected: got msgid %0h expected none", pfd.msgid);
        end else begin
          m_f = fq.pop_front();
          check("fb_msgid", pfd.msgid, m_f);
        end
      end
      if (|fb_valid) check("fb_grant_onehot", $onehot0(fb_ready), 1);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    task_valid = 1'b0; fb_valid = '0; cready = '1; pready = 1'b1; mode = 2'b00;
    repeat (2) @(posedge clk);
    tq.delete();
    fq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Leaves task_valid asserted; caller deasserts when the stream ends.
  task automatic send_task(input logic [1:0] md, input logic [15:0] id, input int bytes,
                           input int exp_cl, input bit immediate);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    task_valid = 1'b1;
    task_descr.msgid        = id;
    task_descr.handler_addr = {16'hbeef, id};
    task_bytes = BW'(bytes);
    mode = md;
    while (!done) begin
      @(negedge clk);
      if (immediate && waited == 0) check("task_ready_immediate", task_ready, 1);
      if (task_ready) begin
        tq.push_back('{exp_cl, id, cyc + 1});
        done = 1;
      end else if (waited > 20) begin
        checks++; errors++;
        $display("FAIL task_accept_timeout msgid %0h: got no accept expected accept", id);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_fb(input int cl, input logic [15:0] id, input int bytes, input bit push);
    int waited;
    bit done;
    waited = 0;
    done   = 0;
    fb_valid[cl]       = 1'b1;
    fb[cl].msgid       = id;
    fb[cl].status      = 8'h5a;
    fb_bytes[cl]       = BW'(bytes);
    while (!done) begin
      @(negedge clk);
      if (fb_ready[cl]) begin
        if (push) fq.push_back(id);
        done = 1;
      end else if (waited > 20) begin
        checks++; errors++;
        $display("FAIL fb_grant_timeout cluster %0d: got no grant expected grant", cl);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    fb_valid[cl] = 1'b0;
  endtask

  int rr_exp[6] = '{1, 2, 3, 0, 1, 2};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_task_ready", task_ready, 0);
    check("rst_ctv", ctv, 0);
    check("rst_ctd", ctd[2].msgid, 0);
    check("rst_pfv", pfv, 0);
    check("rst_fb_ready", fb_ready, 0);
    check("rst_occ_err", occ_err, 0);
    do_reset();

    // Home-first, msgid 6 -> cluster 2
    send_task(2'b00, 16'h0006, 256, 2, 1);
    task_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t1_slot2", dut.slot_occ_q[2], 1);
    check("t1_byte2", dut.byte_occ_q[2], 256);

    // Home cluster full on slots -> least-loaded with tie to lowest index
    do_reset();
    send_task(2'b00, 16'h1000, 300, 0, 1);
    send_task(2'b00, 16'h1002, 100, 2, 1);
    send_task(2'b00, 16'h1003, 100, 3, 1);
    for (int k = 0; k < MS; k++) send_task(2'b00, 16'h2001 + 16'(k * 4), 10, 1, 1);
    send_task(2'b00, 16'h0005, 50, 2, 1);
    task_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t2_slot1_full", dut.slot_occ_q[1], MS);
    check("t2_byte2", dut.byte_occ_q[2], 150);

    // Round-robin from reset pointer
    do_reset();
    for (int k = 0; k < 6; k++) send_task(2'b10, 16'h0300 + 16'(k), 10, rr_exp[k], 1);
    task_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Byte limit stall, released by feedback on cluster 3
    do_reset();
    for (int k = 0; k < 4; k++) send_task(2'b00, 16'h0400 + 16'(k), 900, k, 1);
    task_valid = 1'b1;
    task_descr.msgid = 16'h0440;
    task_descr.handler_addr = 32'h0;
    task_bytes = BW'(200);
    mode = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_ready", task_ready, 0);
      @(posedge clk); #1;
    end
    fb_valid[3] = 1'b1;
    fb[3].msgid = 16'hf403;
    fb[3].status = 8'h00;
    fb_bytes[3] = BW'(100);
    @(negedge clk);
    check("t4_stall_fb_cycle", task_ready, 0);
    check("t4_fb_grant", fb_ready, 4'b1000);
    fq.push_back(16'hf403);
    @(posedge clk); #1;
    fb_valid = '0;
    @(negedge clk);
    check("t4_unstall_ready", task_ready, 1);
    tq.push_back('{3, 16'h0440, cyc + 1});
    @(posedge clk); #1;
    task_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t4_byte3", dut.byte_occ_q[3], 1000);

    // Same-cycle reserve and release, then underflow
    do_reset();
    send_task(2'b00, 16'h0500, 64, 0, 1);
    task_valid = 1'b0;
    @(posedge clk); #1;
    fork
      send_task(2'b00, 16'h0504, 128, 0, 1);
      send_fb(0, 16'hf500, 64, 1);
    join
    task_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t5_slot0_net", dut.slot_occ_q[0], 1);
    check("t5_byte0_net", dut.byte_occ_q[0], 128);
    check("t5_no_err", occ_err, 0);
    send_fb(1, 16'hf501, 10, 1);
    repeat (2) @(posedge clk); #1;
    check("t5_slot1_sat", dut.slot_occ_q[1], 0);
    check("t5_byte1_sat", dut.byte_occ_q[1], 0);
    check("t5_err_set", occ_err, 1);
    repeat (3) @(posedge clk); #1;
    check("t5_err_sticky", occ_err, 1);

    // Feedback ordering with toggling pktgen ready
    do_reset();
    send_fb(3, 16'hf603, 0, 1);
    repeat (3) @(posedge clk); #1;
    fq.push_back(16'hf610);
    fq.push_back(16'hf612);
    fq.push_back(16'hf613);
    fork
      send_fb(0, 16'hf610, 0, 0);
      send_fb(2, 16'hf612, 0, 0);
      send_fb(3, 16'hf613, 0, 0);
      begin
        repeat (10) begin
          @(posedge clk); #1;
          pready = ~pready;
        end
      end
    join
    pready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("t6_fq_drained", fq.size(), 0);

    // Reset mid-operation drops held outputs
    pready = 1'b0;
    cready = '0;
    send_task(2'b00, 16'h0702, 20, 2, 1);
    task_valid = 1'b0;
    send_fb(1, 16'hf701, 0, 0);
    @(negedge clk);
    check("t7_ctv_held", ctv, 4'b0100);
    check("t7_pfv_held", pfv, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_rst_ctv", ctv, 0);
    check("t7_rst_pfv", pfv, 0);
    check("t7_rst_slot2", dut.slot_occ_q[2], 0);
    do_reset();

    repeat (3) @(posedge clk); #1;
    check("end_tq_empty", tq.size(), 0);
    check("end_fq_empty", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
